// File: rtl/tappy_scancode.sv
// ---------------------------------------------------------------------------
// tappy_scancode
//   Sits behind the tappy PS/2 receiver. It takes tappy's word/done byte
//   stream and folds the Set-2 prefixes (E0 = extended, F0 = break) into one
//   key event per key action. Events are queued in a small FIFO that the
//   consumer reads through a valid/ready port. When the FIFO is close to full,
//   inhibit is raised so tappy holds the PS/2 device off.
//
//   Optional build macro: TAPPY_PAUSE_SEQ_EN
//     defined   : the 8-byte Pause sequence E1 14 77 E1 F0 14 F0 77 (started
//                 from IDLE) becomes one event {ext=1, rel=0, code=0x77}.
//     undefined : E1 is an ordinary scancode and no pause states exist.
//
// Ports
//   sysclk    in   system clock (same clock as tappy)
//   reset     in   asynchronous, active-high reset
//   word[7:0] in   received byte, valid only while done=1
//   done      in   one-cycle strobe: word holds a new byte
//   inhibit   out  backpressure to tappy (registered occupancy threshold)
//   ev_code   out  scancode at the FIFO head
//   ev_ext    out  head event had the E0 prefix
//   ev_rel    out  head event had the F0 prefix (key release)
//   ev_valid  out  FIFO non-empty
//   ev_ready  in   consumer takes the head when ev_valid & ev_ready
//   err_drop  out  sticky: an event was lost because the FIFO was full
//   err_ovr   out  sticky: device sent an overrun code (0x00 or 0xFF)
//   err_clr   in   synchronous clear of both sticky flags (a set wins)
// ---------------------------------------------------------------------------
module tappy_scancode #(
  parameter int DEPTH    = 8,
  parameter int HEADROOM = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] word,
  input  logic       done,
  output logic       inhibit,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_rel,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       err_drop,
  output logic       err_ovr,
  input  logic       err_clr
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int TW  = $clog2(TIMEOUT);
  localparam int THR = DEPTH - HEADROOM;

  typedef enum logic [3:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXTBRK
`ifdef TAPPY_PAUSE_SEQ_EN
    ,
    S_P1,   // seen E1
    S_P2,   // seen E1 14
    S_P3,   // seen E1 14 77
    S_P4,   // seen E1 14 77 E1
    S_P5,   // seen ... F0
    S_P6,   // seen ... F0 14
    S_P7    // seen ... F0 14 F0
`endif
  } state_t;

  // ---------------------------------------------------------------------
  // Decoder state
  // ---------------------------------------------------------------------
  state_t          r_state;
  logic [TW-1:0]   r_tmo;
  logic            r_push;       // event decoded last cycle, written to FIFO this edge
  logic [9:0]      r_push_ev;    // {ext, rel, code}
  logic            r_err_ovr;
  logic            r_err_drop;
  logic            r_inhibit;

  // Next-state decode
  state_t          w_nxt;
  logic            w_emit;
  logic            w_ext;
  logic            w_rel;
  logic            w_ovr;
  logic            w_reproc;     // examine this byte with IDLE rules
  logic            w_is_ovr;
  logic            w_tmo_hit;

  // FIFO
  logic [9:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_count;
  logic            w_pop;
  logic            w_push_ok;
  logic [9:0]      w_head;

  assign w_is_ovr  = (word == 8'h00) || (word == 8'hFF);
  assign w_tmo_hit = (r_state != S_IDLE) && (r_tmo == TW'(TIMEOUT - 1));

  always_comb begin
    w_nxt    = r_state;
    w_emit   = 1'b0;
    w_ext    = 1'b0;
    w_rel    = 1'b0;
    w_ovr    = 1'b0;
    w_reproc = 1'b0;
    if (done) begin
      case (r_state)
        S_IDLE: w_reproc = 1'b1;
        S_EXT: begin
          if (word == 8'hF0)      w_nxt = S_EXTBRK;
          else if (word == 8'hE0) w_nxt = S_EXT;
          else if (w_is_ovr) begin
            w_ovr = 1'b1;
            w_nxt = S_IDLE;
          end else begin
            w_emit = 1'b1;
            w_ext  = 1'b1;
            w_nxt  = S_IDLE;
          end
        end
        S_BRK: begin
          if ((word == 8'hE0) || (word == 8'hF0)) w_nxt = S_BRK;
          else if (w_is_ovr) begin
            w_ovr = 1'b1;
            w_nxt = S_IDLE;
          end else begin
            w_emit = 1'b1;
            w_rel  = 1'b1;
            w_nxt  = S_IDLE;
          end
        end
        S_EXTBRK: begin
          if ((word == 8'hE0) || (word == 8'hF0)) w_nxt = S_EXTBRK;
          else if (w_is_ovr) begin
            w_ovr = 1'b1;
            w_nxt = S_IDLE;
          end else begin
            w_emit = 1'b1;
            w_ext  = 1'b1;
            w_rel  = 1'b1;
            w_nxt  = S_IDLE;
          end
        end
`ifdef TAPPY_PAUSE_SEQ_EN
        // Any mismatch abandons the sequence and the offending byte is
        // decoded again as though it arrived in IDLE.
        S_P1: if (word == 8'h14) w_nxt = S_P2; else w_reproc = 1'b1;
        S_P2: if (word == 8'h77) w_nxt = S_P3; else w_reproc = 1'b1;
        S_P3: if (word == 8'hE1) w_nxt = S_P4; else w_reproc = 1'b1;
        S_P4: if (word == 8'hF0) w_nxt = S_P5; else w_reproc = 1'b1;
        S_P5: if (word == 8'h14) w_nxt = S_P6; else w_reproc = 1'b1;
        S_P6: if (word == 8'hF0) w_nxt = S_P7; else w_reproc = 1'b1;
        S_P7: begin
          if (word == 8'h77) begin
            w_emit = 1'b1;
            w_ext  = 1'b1;
            w_nxt  = S_IDLE;
          end else begin
            w_reproc = 1'b1;
          end
        end
`endif
        default: w_nxt = S_IDLE;
      endcase

      if (w_reproc) begin
        w_nxt = S_IDLE;
        if (word == 8'hE0)      w_nxt = S_EXT;
        else if (word == 8'hF0) w_nxt = S_BRK;
`ifdef TAPPY_PAUSE_SEQ_EN
        else if (word == 8'hE1) w_nxt = S_P1;
`endif
        else if (w_is_ovr)      w_ovr  = 1'b1;
        else                    w_emit = 1'b1;
      end
    end else if (w_tmo_hit) begin
      // Stale prefix: drop it silently.
      w_nxt = S_IDLE;
    end
  end

  // Decoder registers. The event is staged in r_push so it lands in the FIFO
  // one edge after the done cycle.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tmo     <= '0;
      r_push    <= 1'b0;
      r_push_ev <= '0;
      r_err_ovr <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_push    <= w_emit;
      r_push_ev <= {w_ext, w_rel, word};
      if (done || (r_state == S_IDLE) || w_tmo_hit) r_tmo <= '0;
      else                                          r_tmo <= r_tmo + 1'b1;
      if (w_ovr)        r_err_ovr <= 1'b1;
      else if (err_clr) r_err_ovr <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------
  assign ev_valid  = (r_count != '0);
  assign w_pop     = ev_valid & ev_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push_ok = r_push && ((r_count < CW'(DEPTH)) || w_pop);
  assign w_head    = r_mem[r_rd];

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_err_drop <= 1'b0;
      r_inhibit  <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr] <= r_push_ev;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_push && !w_push_ok) r_err_drop <= 1'b1;
      else if (err_clr)         r_err_drop <= 1'b0;
      r_inhibit <= (r_count >= CW'(THR));
    end
  end

  assign ev_ext   = w_head[9];
  assign ev_rel   = w_head[8];
  assign ev_code  = w_head[7:0];
  assign inhibit  = r_inhibit;
  assign err_drop = r_err_drop;
  assign err_ovr  = r_err_ovr;

endmodule

// File: tb/tb_tappy_scancode.sv
// Randomized bench for tappy_scancode. A reference model working on prefix
// flags and a pause-match index predicts the event stream; a queue holds the
// expected FIFO contents and a negedge monitor compares the DUT each cycle,
// popping the expected head whenever the consumer takes an event.
module tb_tappy_scancode;
  localparam int DEPTH    = 8;
  localparam int HEADROOM = 2;
  localparam int TIMEOUT  = 16;
  localparam int THR      = DEPTH - HEADROOM;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] word   = 8'h00;
  logic       done   = 1'b0;
  logic       ev_ready = 1'b1;
  logic       err_clr  = 1'b0;
  logic       inhibit, ev_ext, ev_rel, ev_valid, err_drop, err_ovr;
  logic [7:0] ev_code;

  tappy_scancode #(.DEPTH(DEPTH), .HEADROOM(HEADROOM), .TIMEOUT(TIMEOUT)) dut (
    .sysclk(sysclk), .reset(reset), .word(word), .done(done),
    .inhibit(inhibit), .ev_code(ev_code), .ev_ext(ev_ext), .ev_rel(ev_rel),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .err_drop(err_drop),
    .err_ovr(err_ovr), .err_clr(err_clr)
  );

  always #5 sysclk = ~sysclk;

  typedef struct packed { logic ext; logic rel; logic [7:0] code; } ev_t;

  int checks = 0;
  int fails  = 0;
  int n_events = 0;

`ifdef TAPPY_PAUSE_SEQ_EN
  localparam bit PAUSE = 1'b1;
`else
  localparam bit PAUSE = 1'b0;
`endif
  logic [7:0] pseq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  // Reference model state
  ev_t    m_fifo[$];
  bit     m_pend;
  ev_t    m_pend_ev;
  bit     m_inh, m_drop, m_ovr;
  bit     m_ext, m_rel;
  int     m_pidx;
  longint cyc = 0;
  longint m_last = -1000000;
  bit     rnd = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // One received byte against the prefix rules.
  task automatic ref_byte(input logic [7:0] b, output bit emit, output ev_t e, output bit ovr);
    bit is_ovr;
    emit = 1'b0; ovr = 1'b0; e = '0;
    is_ovr = (b == 8'h00) || (b == 8'hFF);
    // A pending prefix dies after TIMEOUT byte-free cycles.
    if (cyc - m_last - 1 >= TIMEOUT) begin m_ext = 0; m_rel = 0; m_pidx = 0; end
    m_last = cyc;
    if (m_pidx != 0) begin
      if (b == pseq[m_pidx]) begin
        m_pidx++;
        if (m_pidx == 8) begin
          m_pidx = 0; emit = 1'b1; e = '{ext: 1'b1, rel: 1'b0, code: 8'h77};
        end
        return;
      end
      m_pidx = 0;
    end
    if (b == 8'hF0) m_rel = 1;
    else if (b == 8'hE0) begin if (!m_rel) m_ext = 1; end
    else if (PAUSE && b == 8'hE1 && !m_ext && !m_rel) m_pidx = 1;
    else if (is_ovr) begin ovr = 1; m_ext = 0; m_rel = 0; end
    else begin
      emit = 1'b1; e = '{ext: m_ext, rel: m_rel, code: b};
      m_ext = 0; m_rel = 0;
    end
  endtask

  // Monitor: compare this cycle's outputs, then advance the model across the
  // coming edge using the inputs the bench is driving this cycle.
  always @(negedge sysclk) begin
    bit  pop, emit, ovr, nxt_inh;
    int  sz;
    ev_t e;
    if (reset) begin
      chk("rst_valid", ev_valid, 0); chk("rst_code", ev_code, 0);
      chk("rst_ext", ev_ext, 0);     chk("rst_rel", ev_rel, 0);
      chk("rst_inhibit", inhibit, 0);
      chk("rst_err_drop", err_drop, 0); chk("rst_err_ovr", err_ovr, 0);
      m_fifo.delete(); m_pend = 0; m_inh = 0; m_drop = 0; m_ovr = 0;
      m_ext = 0; m_rel = 0; m_pidx = 0; m_last = -1000000;
    end else begin
      cyc++;
      sz = m_fifo.size();
      chk("ev_valid", ev_valid, sz != 0);
      if (sz != 0) chk("ev_head", {ev_ext, ev_rel, ev_code}, m_fifo[0]);
      chk("inhibit", inhibit, m_inh);
      chk("err_drop", err_drop, m_drop);
      chk("err_ovr", err_ovr, m_ovr);

      pop = (sz != 0) && ev_ready;
      nxt_inh = (sz >= THR);
      if (pop) begin void'(m_fifo.pop_front()); n_events++; end
      if (m_pend) begin
        if (sz < DEPTH || pop) m_fifo.push_back(m_pend_ev);
        else m_drop = 1'b1;
      end
      if (!(m_pend && !(sz < DEPTH || pop)) && err_clr) m_drop = 1'b0;
      emit = 0; ovr = 0; e = '0;
      if (done) ref_byte(word, emit, e, ovr);
      m_pend = emit; m_pend_ev = e;
      if (ovr) m_ovr = 1'b1; else if (err_clr) m_ovr = 1'b0;
      m_inh = nxt_inh;
    end
  end

  task automatic tick();
    @(posedge sysclk); #1;
    if (rnd) begin
      ev_ready = ($urandom_range(0, 3) != 0);
      err_clr  = ($urandom_range(0, 31) == 0);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    word = b; done = 1'b1;
    tick();
    done = 1'b0; word = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  function automatic logic [7:0] rnd_byte();
    int r;
    r = $urandom_range(0, 15);
    case (r)
      0, 1, 2: return 8'hE0;
      3, 4, 5: return 8'hF0;
      6:       return ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      7, 8:    return 8'hE1;
      9:       return 8'h14;
      10:      return 8'h77;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    // Plain, extended, break and doubled-prefix codes
    send(8'h1C, 4);
    send(8'hE0, 0); send(8'hF0, 1); send(8'h75, 3);
    send(8'hF0, 2); send(8'h1C, 3);
    send(8'hE0, 0); send(8'hE0, 0); send(8'h6B, 3);
    // Timeout boundary: exactly TIMEOUT drops the prefix, one less keeps it
    send(8'hE0, TIMEOUT);     send(8'h1C, 3);
    send(8'hE0, TIMEOUT - 1); send(8'h1C, 3);
    // Overrun mid-prefix, then clear
    send(8'hF0, 0); send(8'hFF, 0); send(8'h1C, 3);
    pulse_clr(); tick();
    // Clear in the same cycle as a new overrun: set wins
    err_clr = 1'b1; send(8'h00, 0); err_clr = 1'b0; tick();
    pulse_clr();
    // E1 handling (plain code, or pause sequence when enabled)
    send(8'hE1, 3);
    for (int i = 0; i < 8; i++) send(pseq[i], 1);
    send(8'hE1, 0); send(8'h14, 0); send(8'h1C, 3);
    // Fill past capacity with the consumer stalled, then drain
    ev_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) send(8'h20 + 8'(i), 0);
    repeat (4) tick();
    ev_ready = 1'b1;
    repeat (DEPTH + 4) tick();
    pulse_clr();
    // Reset with events queued and a prefix pending
    ev_ready = 1'b0;
    send(8'h31, 0); send(8'h32, 0); send(8'hE0, 0);
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
    ev_ready = 1'b1;
    send(8'h1C, 3);
    // Randomized traffic
    rnd = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      int gap;
      gap = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3)
          : TIMEOUT - 1 + $urandom_range(0, 2);
      send(rnd_byte(), gap);
      if (n == 1200) begin
        done = 1'b0; reset = 1'b1; tick(); reset = 1'b0; tick();
      end
    end
    rnd = 1'b0; ev_ready = 1'b1; err_clr = 1'b0;
    repeat (DEPTH + 10) tick();
    checks++;
    if (n_events < 100) begin
      fails++;
      $display("FAIL event_count actual=%0d expected>=100", n_events);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
